// File: rtl/mm_fetch_scheduler_if.sv
// Bus bundle between the matrix-multiplier control unit, the fetch
// scheduler and the memory port. The master modport is the scheduler's view.
interface mm_fetch_scheduler_if #(
  parameter int N_BIT_WIDTH = 3,
  parameter int M_BIT_WIDTH = 4,
  parameter int ADDR_WIDTH  = 16
);
  logic                   fetch_row;
  logic                   fetch_col;
  logic [N_BIT_WIDTH-1:0] n;
  logic [M_BIT_WIDTH-1:0] m;
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_gnt;
  logic                   mem_rvalid;
  logic                   fetch_stall;
  logic                   data_stall;
  logic                   data_is_col;
  logic                   err;

  modport master (
    input  fetch_row, fetch_col, n, m, mem_gnt, mem_rvalid,
    output mem_req, mem_addr, fetch_stall, data_stall, data_is_col, err
  );

  modport slave (
    output fetch_row, fetch_col, n, m, mem_gnt, mem_rvalid,
    input  mem_req, mem_addr, fetch_stall, data_stall, data_is_col, err
  );
endinterface

// File: rtl/mm_fetch_scheduler.sv
// Memory-side fetch sequencer for the matrix multiplier. Turns fetch_row /
// fetch_col pulses into single-outstanding req/gnt/rvalid read transactions,
// with one pending slot per kind and rows always served before columns.
module mm_fetch_scheduler #(
  parameter int N           = 8,
  parameter int M           = 10,
  parameter int N_BIT_WIDTH = (N > 1) ? $clog2(N) : 1,
  parameter int M_BIT_WIDTH = (M > 1) ? $clog2(M) : 1,
  parameter int ADDR_WIDTH  = 16,
  parameter int A_BASE      = 0,
  parameter int B_BASE      = 256,
  parameter int A_STRIDE    = 1,
  parameter int B_STRIDE    = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  mm_fetch_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic                   row_v, row_v_n;
  logic [ADDR_WIDTH-1:0]  row_a, row_a_n;
  logic                   col_v, col_v_n;
  logic [ADDR_WIDTH-1:0]  col_a, col_a_n;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_n;
  logic                   is_col_q, is_col_n;
  logic                   err_q, err_n;
  logic                   fetch_stall_q, fetch_stall_n;

  logic [N_BIT_WIDTH-1:0] n_idx;
  logic [M_BIT_WIDTH-1:0] m_idx;
  logic [ADDR_WIDTH-1:0]  row_addr;
  logic [ADDR_WIDTH-1:0]  col_addr;

  assign n_idx = bus.n;
  assign m_idx = bus.m;

  // Line addresses, computed at full address width and wrapping modulo 2^ADDR_WIDTH
  assign row_addr = ADDR_WIDTH'(A_BASE) + ADDR_WIDTH'(n_idx) * ADDR_WIDTH'(A_STRIDE);
  assign col_addr = ADDR_WIDTH'(B_BASE) + ADDR_WIDTH'(m_idx) * ADDR_WIDTH'(B_STRIDE);

  // Next-state logic: launch, queue or drop fetch pulses and follow the memory handshake
  always_comb begin
    state_n  = state;
    row_v_n  = row_v;
    row_a_n  = row_a;
    col_v_n  = col_v;
    col_a_n  = col_a;
    addr_n   = addr_q;
    is_col_n = is_col_q;
    err_n    = err_q;

    case (state)
      ST_IDLE: begin
        if (bus.mem_rvalid) begin
          err_n = 1'b1;
        end
        if (bus.fetch_row) begin
          state_n  = ST_REQ;
          addr_n   = row_addr;
          is_col_n = 1'b0;
          if (bus.fetch_col) begin
            if (col_v) begin
              err_n = 1'b1;
            end else begin
              col_v_n = 1'b1;
              col_a_n = col_addr;
            end
          end
        end else if (bus.fetch_col) begin
          state_n  = ST_REQ;
          addr_n   = col_addr;
          is_col_n = 1'b1;
        end else if (row_v) begin
          state_n  = ST_REQ;
          addr_n   = row_a;
          is_col_n = 1'b0;
          row_v_n  = 1'b0;
        end else if (col_v) begin
          state_n  = ST_REQ;
          addr_n   = col_a;
          is_col_n = 1'b1;
          col_v_n  = 1'b0;
        end
      end

      ST_REQ, ST_WAIT: begin
        if (bus.fetch_row) begin
          if (row_v) begin
            err_n = 1'b1;
          end else begin
            row_v_n = 1'b1;
            row_a_n = row_addr;
          end
        end
        if (bus.fetch_col) begin
          if (col_v) begin
            err_n = 1'b1;
          end else begin
            col_v_n = 1'b1;
            col_a_n = col_addr;
          end
        end

        if (state == ST_REQ) begin
          if (bus.mem_rvalid) begin
            err_n = 1'b1;
          end
          if (bus.mem_gnt) begin
            state_n = ST_WAIT;
          end
        end else if (bus.mem_rvalid) begin
          // Chain straight into the next queued line so back-to-back work skips IDLE
          if (row_v_n) begin
            state_n  = ST_REQ;
            addr_n   = row_a_n;
            is_col_n = 1'b0;
            row_v_n  = 1'b0;
          end else if (col_v_n) begin
            state_n  = ST_REQ;
            addr_n   = col_a_n;
            is_col_n = 1'b1;
            col_v_n  = 1'b0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    fetch_stall_n = (state_n != ST_IDLE) | row_v_n | col_v_n;
  end

  // State, pending slots, launched request and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      row_v         <= 1'b0;
      row_a         <= '0;
      col_v         <= 1'b0;
      col_a         <= '0;
      addr_q        <= '0;
      is_col_q      <= 1'b0;
      err_q         <= 1'b0;
      fetch_stall_q <= 1'b0;
    end else begin
      state         <= state_n;
      row_v         <= row_v_n;
      row_a         <= row_a_n;
      col_v         <= col_v_n;
      col_a         <= col_a_n;
      addr_q        <= addr_n;
      is_col_q      <= is_col_n;
      err_q         <= err_n;
      fetch_stall_q <= fetch_stall_n;
    end
  end

  assign bus.mem_req     = (state == ST_REQ);
  assign bus.mem_addr    = addr_q;
  assign bus.data_stall  = (state == ST_REQ) | ((state == ST_WAIT) & ~bus.mem_rvalid);
  assign bus.fetch_stall = fetch_stall_q;
  assign bus.data_is_col = is_col_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mm_fetch_scheduler.sv
// Directed testbench for mm_fetch_scheduler: a transaction-level model
// (busy / granted flags plus a slot per fetch kind) is compared against the
// DUT every cycle, and hand-computed literals pin the key scenarios.
module tb_mm_fetch_scheduler;

  logic clk;
  logic rst_n;

  int total;
  int bad;
  bit checking;

  mm_fetch_scheduler_if #(.N_BIT_WIDTH(3), .M_BIT_WIDTH(4), .ADDR_WIDTH(16)) bus ();

  mm_fetch_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: one outstanding transaction plus a pending slot per kind (0=row, 1=col)
  bit          m_busy;
  bit          m_granted;
  logic [15:0] m_addr;
  bit          m_col;
  bit          m_pv [2];
  logic [15:0] m_pa [2];
  bit          m_err;

  function automatic logic [15:0] lineAddr(bit kind, int idx);
    int a;
    a = kind ? (256 + idx) : idx;
    return 16'(a);
  endfunction

  task automatic modelLaunch(bit kind, logic [15:0] a);
    m_busy    = 1'b1;
    m_granted = 1'b0;
    m_addr    = a;
    m_col     = kind;
  endtask

  task automatic modelQueue(bit kind, logic [15:0] a);
    if (m_pv[kind]) m_err = 1'b1;
    else begin
      m_pv[kind] = 1'b1;
      m_pa[kind] = a;
    end
  endtask

  task automatic modelLaunchPending();
    for (int k = 0; k < 2; k++) begin
      if (m_pv[k]) begin
        m_pv[k] = 1'b0;
        modelLaunch(k[0], m_pa[k]);
        return;
      end
    end
  endtask

  // Model update on every clock edge and on asynchronous reset
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_granted = 0; m_addr = '0; m_col = 0; m_err = 0;
        m_pv[0] = 0; m_pv[1] = 0; m_pa[0] = '0; m_pa[1] = '0;
      end else if (!m_busy) begin
        if (bus.mem_rvalid) m_err = 1'b1;
        if (bus.fetch_row) begin
          modelLaunch(1'b0, lineAddr(1'b0, int'(bus.n)));
          if (bus.fetch_col) modelQueue(1'b1, lineAddr(1'b1, int'(bus.m)));
        end else if (bus.fetch_col) begin
          modelLaunch(1'b1, lineAddr(1'b1, int'(bus.m)));
        end else begin
          modelLaunchPending();
        end
      end else begin
        if (bus.fetch_row) modelQueue(1'b0, lineAddr(1'b0, int'(bus.n)));
        if (bus.fetch_col) modelQueue(1'b1, lineAddr(1'b1, int'(bus.m)));
        if (!m_granted) begin
          if (bus.mem_rvalid) m_err = 1'b1;
          if (bus.mem_gnt) m_granted = 1'b1;
        end else if (bus.mem_rvalid) begin
          m_busy    = 1'b0;
          m_granted = 1'b0;
          modelLaunchPending();
        end
      end
    end
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cyc_mem_req", 32'(bus.mem_req), 32'(m_busy && !m_granted));
      if (m_busy && !m_granted) checkOutput("cyc_mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      checkOutput("cyc_data_stall", 32'(bus.data_stall), 32'(m_busy && !(m_granted && bus.mem_rvalid)));
      checkOutput("cyc_fetch_stall", 32'(bus.fetch_stall), 32'(m_busy || m_pv[0] || m_pv[1]));
      checkOutput("cyc_data_is_col", 32'(bus.data_is_col), 32'(m_col));
      checkOutput("cyc_err", 32'(bus.err), 32'(m_err));
    end
  end

  task automatic applyStimulus(bit fr, bit fc, int nv, int mv, bit g, bit rv);
    bus.fetch_row  = fr;
    bus.fetch_col  = fc;
    bus.n          = 3'(nv);
    bus.m          = 4'(mv);
    bus.mem_gnt    = g;
    bus.mem_rvalid = rv;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkAllZero(string tag);
    checkOutput({tag, "_mem_req"}, 32'(bus.mem_req), 0);
    checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    checkOutput({tag, "_fetch_stall"}, 32'(bus.fetch_stall), 0);
    checkOutput({tag, "_data_stall"}, 32'(bus.data_stall), 0);
    checkOutput({tag, "_data_is_col"}, 32'(bus.data_is_col), 0);
    checkOutput({tag, "_err"}, 32'(bus.err), 0);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkAllZero("rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios
  initial begin
    total = 0;
    bad = 0;
    checking = 0;
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checking = 1;
    checkAllZero("reset");
    rst_n = 1'b1;

    // Single row fetch, zero-wait grant, rvalid two cycles after grant
    applyStimulus(1, 0, 3, 0, 0, 0); step();
    checkOutput("t1_req", 32'(bus.mem_req), 1);
    checkOutput("t1_addr", 32'(bus.mem_addr), 3);
    checkOutput("t1_fstall", 32'(bus.fetch_stall), 1);
    applyStimulus(0, 0, 0, 0, 1, 0); step();
    checkOutput("t1_req_drop", 32'(bus.mem_req), 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("t1_dstall_rv", 32'(bus.data_stall), 0);
    step();
    checkOutput("t1_fstall_done", 32'(bus.fetch_stall), 0);
    checkOutput("t1_is_col", 32'(bus.data_is_col), 0);
    checkOutput("t1_err", 32'(bus.err), 0);

    // Row and column together: row first, column chained without an IDLE gap
    applyStimulus(1, 1, 2, 5, 0, 0); step();
    checkOutput("t2_addr_row", 32'(bus.mem_addr), 2);
    applyStimulus(0, 0, 0, 0, 1, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 1); step();
    checkOutput("t2_req_col", 32'(bus.mem_req), 1);
    checkOutput("t2_addr_col", 32'(bus.mem_addr), 261);
    checkOutput("t2_is_col", 32'(bus.data_is_col), 1);
    checkOutput("t2_fstall", 32'(bus.fetch_stall), 1);

    // Grant withheld for four cycles: request held stable
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_req_hold", 32'(bus.mem_req), 1);
      checkOutput("t3_addr_hold", 32'(bus.mem_addr), 261);
      checkOutput("t3_dstall_hold", 32'(bus.data_stall), 1);
      step();
    end
    applyStimulus(0, 0, 0, 0, 1, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 1); step();
    checkOutput("t3_fstall_done", 32'(bus.fetch_stall), 0);

    // Two column pulses in WAIT: first queued, second dropped with err
    applyStimulus(1, 0, 1, 0, 0, 0); step();
    applyStimulus(0, 0, 0, 0, 1, 0); step();
    applyStimulus(0, 1, 0, 4, 0, 0); step();
    checkOutput("t4_err_first", 32'(bus.err), 0);
    applyStimulus(0, 1, 0, 7, 0, 0); step();
    checkOutput("t4_err_drop", 32'(bus.err), 1);
    applyStimulus(0, 0, 0, 0, 0, 1); step();
    checkOutput("t4_addr_queued", 32'(bus.mem_addr), 260);
    applyStimulus(0, 0, 0, 0, 1, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 1); step();
    step();
    checkOutput("t4_err_sticky", 32'(bus.err), 1);
    checkOutput("t4_idle_req", 32'(bus.mem_req), 0);

    // Stray rvalid while idle
    pulseReset();
    applyStimulus(0, 0, 0, 0, 0, 1); step();
    checkOutput("t5_err", 32'(bus.err), 1);
    checkOutput("t5_req", 32'(bus.mem_req), 0);
    checkOutput("t5_fstall", 32'(bus.fetch_stall), 0);

    // Reset while waiting with a pending row: the row is never issued
    pulseReset();
    applyStimulus(0, 1, 0, 9, 0, 0); step();
    checkOutput("t6_addr_pre", 32'(bus.mem_addr), 265);
    applyStimulus(0, 0, 0, 0, 1, 0); step();
    applyStimulus(1, 0, 6, 0, 0, 0); step();
    checkOutput("t6_fstall_pend", 32'(bus.fetch_stall), 1);
    pulseReset();
    applyStimulus(0, 1, 0, 0, 0, 0); step();
    checkOutput("t6_addr_col0", 32'(bus.mem_addr), 256);
    checkOutput("t6_is_col", 32'(bus.data_is_col), 1);
    applyStimulus(0, 0, 0, 0, 1, 0); step();
    applyStimulus(0, 0, 0, 0, 0, 1); step();
    checkOutput("t6_fstall_done", 32'(bus.fetch_stall), 0);
    step();
    step();
    checkOutput("t6_no_old_row", 32'(bus.mem_req), 0);

    step();
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
